pe_step_sequencer: RTL and testbench
====================================

# pe_step_sequencer

Sequential controller that drives one neuron PE's `config_sig` and `x_mem` inputs and collects its `y_outmem` results. It sits directly upstream of the PE:
- A host preloads a small program memory of 30-bit config words and an input-activation memory.
- On `start`, the block steps through the program, holding each word for a fixed settle window.
- On steps whose WR bit is set, it captures the PE result into a streaming output.

## Interface
Parameters:
- DEPTH, 16, number of program entries and input-activation entries (power of two, ≥2).
- AW, $clog2(DEPTH), address width.
- SETTLE, 2, cycles each config word is held before `y_outmem` is sampled (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  AW  program write address.
- prog_data  in  30  config word {w1[7:0], w2[7:0], b[7:0], shif[1:0], slope[1:0], RD, WR}.
- xmem_we  in  1  input-memory write strobe.
- xmem_addr  in  AW  input write address.
- xmem_data  in  8  activation byte.
- start  in  1  one-cycle run request.
- num_steps  in  AW+1  steps to execute, 0..DEPTH.
- config_sig  out  30  registered config word to the PE.
- x_mem  out  8  registered activation to the PE.
- y_outmem  in  8  PE memory-side result.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- out_valid  out  1  one-cycle strobe for a captured result.
- out_data  out  8  captured result.
- out_idx  out  AW  step index of the captured result.

## Operation
- States:
  - IDLE: waiting for `start`.
  - HOLD: config word being driven and allowed to settle.
  - DONE: one-cycle completion state.
- IDLE:
  - `config_sig` = 0, `x_mem` = 0.
  - Memory writes are accepted.
  - `start` latches n = min(num_steps, DEPTH).
  - If n = 0, go to DONE; otherwise set step = 0 and go to HOLD.
- HOLD:
  - `config_sig` = prog[step], `x_mem` = xmem[step].
  - A hold counter runs 0..SETTLE.
  - When the counter reaches SETTLE, `y_outmem` is sampled.
  - If prog[step][0] (WR) = 1, `out_valid` pulses the next cycle with `out_data` = sampled value and `out_idx` = step.
  - If WR = 0, no output is produced for that step.
  - Then step increments. If step was n−1, go to DONE; otherwise reload the counter and stay in HOLD with the new word.
- DONE: `done` = 1 for one cycle, `config_sig` and `x_mem` return to 0, next state is IDLE.
- The block does not interpret RD. It is passed through to the PE, and `x_mem` is driven regardless of RD.
- `prog_we` and `xmem_we` are ignored while `busy` = 1, so memory contents are stable during a run.
- `start` while `busy` = 1 is ignored.
- A write and a `start` in the same IDLE cycle: the write commits, and the run uses the new contents.
- `num_steps` > DEPTH is clamped to DEPTH.
- `step` never wraps: the run ends at n−1.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - `config_sig`, `x_mem`, `out_data`, `out_idx` = 0.
  - `busy`, `done`, `out_valid` = 0.
- Reset mid-run aborts immediately. No `done` pulse; memory contents are undefined-preserved (not cleared).
- `start` sampled at edge T0:
  - At T0+1, `config_sig` and `x_mem` present step 0 and `busy` = 1.
- Each step occupies exactly SETTLE+1 cycles.
  - `y_outmem` is sampled on the edge ending the step's last cycle.
  - `out_valid` is high during the first cycle of the following step (or the DONE cycle, for the last step).
- For n ≥ 1, `done` is high at cycle T0+1+n·(SETTLE+1). For n = 0, `done` is high at T0+1.
- `busy` drops the cycle after `done`. A new `start` is accepted in that cycle or later.
- Back-to-back steps present a new config word with no bubble cycle.

## Structure
- A shared package `pe_pkg` holds:
  - CFG_W = 30.
  - Field offsets: WR_BIT = 0, RD_BIT = 1, SLOPE_LSB = 2, SHIF_LSB = 4, B_LSB = 6, W2_LSB = 14, W1_LSB = 22.
  - The state enum {IDLE, HOLD, DONE}.
- One sub-module: `pe_seq_regfile`, a parameterised write-port/async-read-port register array. It is instantiated twice: 30-bit program memory and 8-bit activation memory.
- FSM, counters and output registers live in the top module.

## Test plan
- Reset: hold rst_n low mid-run at step 2 -> all outputs 0 next cycle, no `done`, and state is IDLE after release.
- Basic run: SETTLE=2, n=3, prog WR bits 1,0,1, `y_outmem` driven as 0x11/0x22/0x33 per step:
  - `out_valid` fires twice: (0x11, idx 0) and (0x33, idx 2).
  - `done` occurs at T0+10.
- n=0 -> `done` at T0+1, `busy` for one cycle, `config_sig` stays 0.
- num_steps=31 with DEPTH=16 -> exactly 16 steps, `done` at T0+1+16·3, with no address wrap.
- `start` and `prog_we` asserted during busy -> both ignored. A second `start` the cycle after `busy` falls -> new run begins.
- Same-cycle `prog_we` to addr 0 (word with w1=0xA5) and `start` -> step 0 `config_sig`[29:22] = 0xA5.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared config-word layout and sequencer state encoding
package pe_pkg;

  localparam int CFG_W     = 30;
  localparam int WR_BIT    = 0;
  localparam int RD_BIT    = 1;
  localparam int SLOPE_LSB = 2;
  localparam int SHIF_LSB  = 4;
  localparam int B_LSB     = 6;
  localparam int W2_LSB    = 14;
  localparam int W1_LSB    = 22;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

  function automatic logic [7:0] cfg_w1(input logic [CFG_W-1:0] cfg);
    return cfg[W1_LSB +: 8];
  endfunction

endpackage

// File: rtl/pe_step_sequencer_if.sv
// rtl/pe_step_sequencer_if.sv - host/PE-facing bundle of the step sequencer
interface pe_step_sequencer_if
  import pe_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) ();

  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [CFG_W-1:0] prog_data;
  logic             xmem_we;
  logic [AW-1:0]    xmem_addr;
  logic [7:0]       xmem_data;
  logic             start;
  logic [AW:0]      num_steps;
  logic [CFG_W-1:0] config_sig;
  logic [7:0]       x_mem;
  logic [7:0]       y_outmem;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [AW-1:0]    out_idx;

  modport master (
    output prog_we, prog_addr, prog_data, xmem_we, xmem_addr, xmem_data,
    output start, num_steps, y_outmem,
    input  config_sig, x_mem, busy, done, out_valid, out_data, out_idx
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, xmem_we, xmem_addr, xmem_data,
    input  start, num_steps, y_outmem,
    output config_sig, x_mem, busy, done, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/pe_seq_regfile.sv
// rtl/pe_seq_regfile.sv - single write port, asynchronous read port register array
module pe_seq_regfile #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Contents deliberately survive reset so a program can be rerun after an abort.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_step_sequencer.sv
// rtl/pe_step_sequencer.sv - steps a PE through a preloaded program, capturing results on WR steps
module pe_step_sequencer
  import pe_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_step_sequencer_if.slave bus
);

  localparam int          CW      = $clog2(SETTLE + 1);
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    step;
  logic [AW-1:0]    last_step;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rd_addr;
  logic [CFG_W-1:0] prog_rd;
  logic [7:0]       x_rd;
  logic             mem_we_ok;
  logic [AW:0]      n_clamped;
  logic [CFG_W-1:0] first_cfg;
  logic [7:0]       first_x;

  assign mem_we_ok = (state == IDLE);
  assign n_clamped = (bus.num_steps > DEPTH_N) ? DEPTH_N : bus.num_steps;

  // Prefetch the word for the next step so consecutive steps have no bubble.
  assign rd_addr = (state == IDLE) ? '0 : step + AW'(1);

  // A write landing in the start cycle must be visible to step 0.
  assign first_cfg = (bus.prog_we && bus.prog_addr == '0) ? bus.prog_data : prog_rd;
  assign first_x   = (bus.xmem_we && bus.xmem_addr == '0) ? bus.xmem_data : x_rd;

  pe_seq_regfile #(.W(CFG_W), .DEPTH(DEPTH), .AW(AW)) u_prog (
    .clk   (clk),
    .we    (bus.prog_we && mem_we_ok),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (rd_addr),
    .rdata (prog_rd)
  );

  pe_seq_regfile #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_xmem (
    .clk   (clk),
    .we    (bus.xmem_we && mem_we_ok),
    .waddr (bus.xmem_addr),
    .wdata (bus.xmem_data),
    .raddr (rd_addr),
    .rdata (x_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      step           <= '0;
      last_step      <= '0;
      cnt            <= '0;
      bus.config_sig <= '0;
      bus.x_mem      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_idx    <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            step     <= '0;
            cnt      <= '0;
            if (n_clamped == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state          <= HOLD;
              last_step      <= AW'(n_clamped - (AW + 1)'(1));
              bus.config_sig <= first_cfg;
              bus.x_mem      <= first_x;
            end
          end
        end
        HOLD: begin
          if (cnt == CW'(SETTLE)) begin
            cnt           <= '0;
            bus.out_valid <= bus.config_sig[WR_BIT];
            bus.out_data  <= bus.y_outmem;
            bus.out_idx   <= step;
            if (step == last_step) begin
              state          <= DONE;
              bus.done       <= 1'b1;
              bus.config_sig <= '0;
              bus.x_mem      <= '0;
            end else begin
              step           <= step + AW'(1);
              bus.config_sig <= prog_rd;
              bus.x_mem      <= x_rd;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_step_sequencer.sv
// tb/tb_pe_step_sequencer.sv - randomized self-checking bench against a cycle-table reference model
module tb_pe_step_sequencer;
  import pe_pkg::*;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 2;
  localparam int SP     = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n;

  pe_step_sequencer_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  pe_step_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CFG_W-1:0] prog_m [DEPTH];
  logic [7:0]       xmem_m [DEPTH];
  logic [7:0]       y_m    [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_mem(input int a, input logic [CFG_W-1:0] p, input logic [7:0] x);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(a);
    bus.prog_data = p;
    bus.xmem_we   = 1'b1;
    bus.xmem_addr = 4'(a);
    bus.xmem_data = x;
    prog_m[a] = p;
    xmem_m[a] = x;
    @(negedge clk);
    bus.prog_we = 1'b0;
    bus.xmem_we = 1'b0;
  endtask

  task automatic randomize_y();
    for (int i = 0; i < DEPTH; i++) y_m[i] = 8'($urandom);
  endtask

  // Called at a negedge with the sequencer idle; returns at the first idle negedge after done.
  task automatic run(input int n_req, input bit wr0, input logic [CFG_W-1:0] wr0_data,
                     input bit disturb);
    int n, done_k, ps;
    bit exp_v;
    logic [CFG_W-1:0] exp_cfg;
    logic [7:0] exp_x;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    done_k = (n == 0) ? 1 : 1 + n * SP;
    bus.start     = 1'b1;
    bus.num_steps = 5'(n_req);
    bus.y_outmem  = 8'h00;
    if (wr0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = wr0_data;
      prog_m[0]     = wr0_data;
    end
    @(negedge clk);
    for (int k = 1; k <= done_k + 1; k++) begin
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      bus.xmem_we = 1'b0;
      exp_cfg = '0;
      exp_x   = '0;
      if (n > 0 && k <= n * SP) begin
        exp_cfg = prog_m[(k - 1) / SP];
        exp_x   = xmem_m[(k - 1) / SP];
      end
      exp_v = 1'b0;
      ps = -1;
      if (k >= SP + 1 && (k - 1) % SP == 0) begin
        ps = (k - 1) / SP - 1;
        if (ps < n) exp_v = prog_m[ps][WR_BIT];
      end
      check($sformatf("cfg n%0d k%0d", n_req, k), 32'(bus.config_sig), 32'(exp_cfg));
      check($sformatf("x n%0d k%0d", n_req, k), 32'(bus.x_mem), 32'(exp_x));
      check($sformatf("busy n%0d k%0d", n_req, k), 32'(bus.busy), 32'(k <= done_k));
      check($sformatf("done n%0d k%0d", n_req, k), 32'(bus.done), 32'(k == done_k));
      check($sformatf("oval n%0d k%0d", n_req, k), 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("odata n%0d k%0d", n_req, k), 32'(bus.out_data), 32'(y_m[ps]));
        check($sformatf("oidx n%0d k%0d", n_req, k), 32'(bus.out_idx), 32'(ps));
      end
      bus.y_outmem = (n > 0 && k <= n * SP) ? y_m[(k - 1) / SP] : 8'h00;
      if (disturb && n > 0 && k == 2) begin
        bus.start     = 1'b1;
        bus.num_steps = 5'($urandom_range(0, 31));
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'($urandom);
        bus.prog_data = 30'($urandom);
        bus.xmem_we   = 1'b1;
        bus.xmem_addr = 4'($urandom);
        bus.xmem_data = 8'($urandom);
      end
      if (k <= done_k) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.xmem_we   = 1'b0;
    bus.xmem_addr = '0;
    bus.xmem_data = '0;
    bus.start     = 1'b0;
    bus.num_steps = '0;
    bus.y_outmem  = '0;
    repeat (2) @(negedge clk);
    check("rst cfg", 32'(bus.config_sig), 0);
    check("rst x", 32'(bus.x_mem), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst oval", 32'(bus.out_valid), 0);
    check("rst odata", 32'(bus.out_data), 0);
    check("rst oidx", 32'(bus.out_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) write_mem(i, 30'($urandom), 8'($urandom));

    // Basic run: WR pattern 1,0,1 with fixed PE results.
    write_mem(0, 30'($urandom) | 30'h1, 8'($urandom));
    write_mem(1, 30'($urandom) & ~30'h1, 8'($urandom));
    write_mem(2, 30'($urandom) | 30'h1, 8'($urandom));
    randomize_y();
    y_m[0] = 8'h11;
    y_m[1] = 8'h22;
    y_m[2] = 8'h33;
    run(3, 1'b0, '0, 1'b0);

    run(0, 1'b0, '0, 1'b0);

    randomize_y();
    run(31, 1'b0, '0, 1'b0);

    // Disturbed run, then an immediate restart the cycle busy falls.
    randomize_y();
    run(5, 1'b0, '0, 1'b1);
    randomize_y();
    run(4, 1'b0, '0, 1'b0);

    // Same-cycle write to address 0 and start.
    randomize_y();
    run(2, 1'b1, {8'hA5, 22'($urandom)}, 1'b0);
    check("w1 model", 32'(cfg_w1(prog_m[0])), 32'hA5);

    // Reset while step 2 is being held.
    bus.start     = 1'b1;
    bus.num_steps = 5'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst cfg", 32'(bus.config_sig), 0);
    check("mid rst x", 32'(bus.x_mem), 0);
    check("mid rst busy", 32'(bus.busy), 0);
    check("mid rst done", 32'(bus.done), 0);
    check("mid rst oval", 32'(bus.out_valid), 0);
    check("mid rst odata", 32'(bus.out_data), 0);
    check("mid rst oidx", 32'(bus.out_idx), 0);
    @(negedge clk);
    check("mid rst done2", 32'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst busy", 32'(bus.busy), 0);
    check("post rst done", 32'(bus.done), 0);
    check("post rst cfg", 32'(bus.config_sig), 0);
    randomize_y();
    run(6, 1'b0, '0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      randomize_y();
      run($urandom_range(0, 20), 1'($urandom), 30'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
